// File: rtl/debug_tap_pkg.sv
// debug_tap_pkg: shared mode encoding and page-select width helper for debug_tap.
//   mode_e : 2-bit processing mode (LIVE, CAPTURE, COUNT, PEAK)
//   pg_w() : width of the page select, never narrower than 1 bit
package debug_tap_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE    = 2'b00,
        MODE_CAPTURE = 2'b01,
        MODE_COUNT   = 2'b10,
        MODE_PEAK    = 2'b11
    } mode_e;

    function automatic int pg_w(input int npage);
        return (npage > 1) ? $clog2(npage) : 1;
    endfunction

endpackage

// File: rtl/debug_tap_capture.sv
// debug_tap_capture: capture register implementing the four observation modes.
//   clk, rst       : clock and synchronous active-high reset
//   s_i, v_i       : selected channel sample and its strobe
//   mode_i         : registered processing mode
//   clear_i        : clear (external clear or reconfiguration), beats freeze and strobes
//   freeze_i       : hold cap_o / cap_valid_o
//   cap_o          : capture register
//   cap_valid_o    : at least one update since the last clear or reset
module debug_tap_capture
    import debug_tap_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_i,
    input  logic              v_i,
    input  mode_e             mode_i,
    input  logic              clear_i,
    input  logic              freeze_i,
    output logic [DATA_W-1:0] cap_o,
    output logic              cap_valid_o
);

    logic [DATA_W-1:0] cap_q, cap_d;
    logic              valid_q, valid_d;

    always_comb begin
        cap_d   = cap_q;
        valid_d = valid_q;
        if (clear_i) begin
            cap_d   = '0;
            valid_d = 1'b0;
        end else if (!freeze_i) begin
            case (mode_i)
                MODE_LIVE: begin
                    cap_d   = s_i;
                    valid_d = 1'b1;
                end
                MODE_CAPTURE: if (v_i) begin
                    cap_d   = s_i;
                    valid_d = 1'b1;
                end
                // Saturates at all-ones so a long event burst never wraps back to small values.
                MODE_COUNT: if (v_i) begin
                    cap_d   = (&cap_q) ? cap_q : cap_q + 1'b1;
                    valid_d = 1'b1;
                end
                // The first sample after a clear is always taken, whatever its value.
                MODE_PEAK: if (v_i) begin
                    cap_d   = (!valid_q || s_i > cap_q) ? s_i : cap_q;
                    valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cap_q   <= cap_d;
            valid_q <= valid_d;
        end
    end

    assign cap_o       = cap_q;
    assign cap_valid_o = valid_q;

endmodule

// File: rtl/debug_tap.sv
// debug_tap: selects a probe channel, processes it in one of four modes and shows one page on the LEDs.
//   clk, rst      : clock and synchronous active-high reset
//   ch_data_i     : packed probe data, channel i at [i*DATA_W +: DATA_W]
//   ch_valid_i    : per-channel sample strobe
//   ch_sel_i      : selected channel (out-of-range reads as s=0, v=0)
//   mode_i        : 00 LIVE, 01 CAPTURE, 10 COUNT, 11 PEAK
//   page_i        : OUT_W-wide page of the capture register to display
//   freeze_i      : hold the capture register
//   clear_i       : clear the capture register
//   led_o         : registered displayed page
//   cap_valid_o   : capture register updated since last clear/reset/reconfiguration
module debug_tap
    import debug_tap_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int NPAGE  = DATA_W / OUT_W,
    parameter int PG_W   = pg_w(NPAGE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]        ch_valid_i,
    input  logic [SEL_W-1:0]         ch_sel_i,
    input  logic [1:0]               mode_i,
    input  logic [PG_W-1:0]          page_i,
    input  logic                     freeze_i,
    input  logic                     clear_i,
    output logic [OUT_W-1:0]         led_o,
    output logic                     cap_valid_o
);

    logic [SEL_W-1:0]  sel_q;
    mode_e             mode_q;
    logic [OUT_W-1:0]  led_q, led_d;
    logic [DATA_W-1:0] s, cap;
    logic              v, reconfig;

    // Matching against each valid index leaves out-of-range selects at s=0, v=0.
    always_comb begin
        s = '0;
        v = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel_i == SEL_W'(i)) begin
                s = ch_data_i[i*DATA_W +: DATA_W];
                v = ch_valid_i[i];
            end
        end
    end

    assign reconfig = (ch_sel_i != sel_q) || (mode_i != mode_q);

    // Pages at or beyond NPAGE display zero.
    always_comb begin
        led_d = '0;
        for (int p = 0; p < NPAGE; p++) begin
            if (page_i == PG_W'(p)) led_d = cap[p*OUT_W +: OUT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            mode_q <= MODE_LIVE;
            led_q  <= '0;
        end else begin
            sel_q  <= ch_sel_i;
            mode_q <= mode_e'(mode_i);
            led_q  <= led_d;
        end
    end

    debug_tap_capture #(.DATA_W(DATA_W)) u_capture (
        .clk         (clk),
        .rst         (rst),
        .s_i         (s),
        .v_i         (v),
        .mode_i      (mode_q),
        .clear_i     (clear_i | reconfig),
        .freeze_i    (freeze_i),
        .cap_o       (cap),
        .cap_valid_o (cap_valid_o)
    );

    assign led_o = led_q;

endmodule
